// File: rtl/countdown_timer_prog.sv
// countdown_timer_prog: loadable seconds countdown timer with a 1 Hz prescaler.
// Supports start/pause/stop control, one-shot or auto-reload mode and a
// one-cycle expiry pulse.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   load_value  value captured by load
//   load        strobe: capture load_value (reload register only while running)
//   start       strobe: run or resume
//   pause       strobe: freeze count and prescaler
//   stop        strobe: abort, count <- reload register
//   auto_reload 1 = reload and keep running after expiry, 0 = one-shot
//   count       seconds remaining
//   running     high while in RUN
//   tick        one-cycle 1 Hz strobe, only in RUN
//   done        one-cycle pulse when count reaches 0
//
// Build option: define TIMER_FAST_SIM_EN to force a tick every 4 cycles
// (simulation only); otherwise the prescaler terminal count is CLK_FREQ_HZ-1.

module countdown_timer_prog #(
  parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
  parameter int unsigned CNT_WIDTH    = 6,
  parameter int unsigned DEFAULT_LOAD = 59
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 load,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 stop,
  input  logic                 auto_reload,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 running,
  output logic                 tick,
  output logic                 done
);

  localparam int unsigned PRE_W_BASE = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
`ifdef TIMER_FAST_SIM_EN
  // Fast-sim terminal count of 3 needs at least 2 prescaler bits.
  localparam int unsigned PRE_W  = (PRE_W_BASE < 2) ? 2 : PRE_W_BASE;
  localparam int unsigned TC_VAL = 3;
`else
  localparam int unsigned PRE_W  = PRE_W_BASE;
  localparam int unsigned TC_VAL = (CLK_FREQ_HZ > 0) ? CLK_FREQ_HZ - 1 : 0;
`endif

  localparam logic [PRE_W-1:0]     PRE_TC   = PRE_W'(TC_VAL);
  localparam logic [CNT_WIDTH-1:0] LOAD_RST = CNT_WIDTH'(DEFAULT_LOAD);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] reload_q, reload_d;
  logic [PRE_W-1:0]     pre_q, pre_d;
  logic                 running_q, running_d;
  logic                 tick_q, tick_d;
  logic                 done_q, done_d;
  logic                 advance;

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= LOAD_RST;
      reload_q  <= LOAD_RST;
      pre_q     <= '0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      pre_q     <= pre_d;
      running_q <= running_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
    end
  end

  // Strobe decode (stop > load > start > pause), then prescaler/count update.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    pre_d    = pre_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    advance  = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      count_d = reload_q;
      pre_d   = '0;
    end else if (load) begin
      reload_d = load_value;
      if (state_q == ST_RUN) begin
        // Running count keeps going; the new value applies at the next reload.
        advance = 1'b1;
      end else begin
        count_d = load_value;
        pre_d   = '0;
        if (state_q == ST_EXPIRED) state_d = ST_IDLE;
      end
    end else if (start) begin
      case (state_q)
        ST_IDLE: begin
          if (count_q != '0) begin
            state_d = ST_RUN;
            pre_d   = '0;
          end
        end
        ST_PAUSED: state_d = ST_RUN;  // partial period preserved
        ST_EXPIRED: begin
          if (reload_q != '0) begin
            state_d = ST_RUN;
            count_d = reload_q;
            pre_d   = '0;
          end
        end
        default: advance = 1'b1;      // RUN: start ignored, keep counting
      endcase
    end else if (pause && (state_q == ST_RUN)) begin
      state_d = ST_PAUSED;
    end else if (state_q == ST_RUN) begin
      advance = 1'b1;
    end

    if (advance) begin
      if (pre_q == PRE_TC) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (count_q > CNT_ONE) begin
          count_d = count_q - CNT_ONE;
        end else if (count_q == CNT_ONE) begin
          count_d = '0;
          done_d  = 1'b1;
          if (!auto_reload) state_d = ST_EXPIRED;
        end else begin
          // Zero already shown for a full second in auto-reload mode.
          count_d = reload_q;
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end

    running_d = (state_d == ST_RUN);
  end

  assign count   = count_q;
  assign running = running_q;
  assign tick    = tick_q;
  assign done    = done_q;

endmodule
